// File: rtl/pdm_clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_pkg
// Description : Shared types and helpers for the PDM microphone blocks.
//               - pdm_clk_state_t : clock controller state encoding
//               - pdm_clamp_half  : saturate a requested half-period into
//                                   the legal [lo, hi] window
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } pdm_clk_state_t;

    // Saturating clamp. Kept 32-bit so every PDM block can share it
    // regardless of its own divider width.
    function automatic int unsigned pdm_clamp_half(
        input int unsigned value,
        input int unsigned lo,
        input int unsigned hi
    );
        int unsigned result;
        result = value;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end
        return result;
    endfunction

endpackage : pdm_pkg
`default_nettype wire

// File: rtl/pdm_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pdm_clk_ctrl_if
// Description : Control / status bundle of the PDM clock controller.
//               master : the capture logic driving en / div_in / div_load
//               slave  : the clock controller producing M_CLK and strobes
//               Signals: en, div_in[DIV_W], div_load (control)
//                        M_CLK, m_clk_rising, m_clk_falling, sample_ch0,
//                        sample_ch1, running, div_pending (status)
// Revision    : 1.0 - initial release
// ============================================================================
interface pdm_clk_ctrl_if #(
    parameter int DIV_W = 8
) ();

    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             M_CLK;
    logic             m_clk_rising;
    logic             m_clk_falling;
    logic             sample_ch0;
    logic             sample_ch1;
    logic             running;
    logic             div_pending;

    modport master (
        output en, div_in, div_load,
        input  M_CLK, m_clk_rising, m_clk_falling,
        input  sample_ch0, sample_ch1, running, div_pending
    );

    modport slave (
        input  en, div_in, div_load,
        output M_CLK, m_clk_rising, m_clk_falling,
        output sample_ch0, sample_ch1, running, div_pending
    );

endinterface : pdm_clk_ctrl_if
`default_nettype wire

// File: rtl/pdm_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdm_clk_ctrl
// Description : Programmable PDM microphone clock generator. Divides clk into
//               M_CLK with a runtime-programmable half-period that is only
//               switched at period starts, starts and stops without runt
//               pulses, and emits edge strobes plus delayed ch0/ch1 sample
//               strobes. All outputs are registered.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - pdm_clk_ctrl_if.slave (en, div_in, div_load in;
//                      M_CLK, edge/sample strobes, running, div_pending out)
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_clk_ctrl #(
    parameter int INPUT_FREQ   = 100_000_000,
    parameter int MAX_HALF     = 128,
    parameter int DEFAULT_HALF = 20,
    parameter int SAMPLE_DELAY = 2,
    parameter int DIV_W        = $clog2(MAX_HALF + 1)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pdm_clk_ctrl_if.slave       bus
);

    import pdm_pkg::*;

    // Static parameter sanity: the sample strobe must land inside a phase.
    if (SAMPLE_DELAY >= DEFAULT_HALF || DEFAULT_HALF > MAX_HALF ||
        INPUT_FREQ <= 0) begin : g_param_check
        $error("pdm_clk_ctrl: inconsistent parameter set");
    end

    localparam logic [DIV_W-1:0] c_DEFAULT_HALF = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] c_SAMPLE_DELAY = DIV_W'(SAMPLE_DELAY);

    pdm_clk_state_t   state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_act_q, half_act_d;
    logic [DIV_W-1:0] half_pend_q, half_pend_d;
    logic             pend_q, pend_d;
    logic             mclk_q, mclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic             running_q, running_d;

    logic [DIV_W-1:0] w_clamped;
    logic [DIV_W-1:0] w_last;
    logic             w_active_d;

    // Minimum half is SAMPLE_DELAY+1 so every phase reaches its sample point.
    assign w_clamped = DIV_W'(pdm_clamp_half(32'(bus.div_in),
                                             SAMPLE_DELAY + 1, MAX_HALF));
    assign w_last    = half_act_q - DIV_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mclk_d      = mclk_q;
        half_act_d  = half_act_q;
        half_pend_d = half_pend_q;
        pend_d      = pend_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                mclk_d = 1'b0;
                if (bus.en) begin
                    state_d = RUN;
                    mclk_d  = 1'b1;
                    rise_d  = 1'b1;
                end
            end
            RUN, STOPPING: begin
                // en is re-sampled every cycle; STOPPING only matters at the
                // end of the low phase, where it suppresses the next rise.
                state_d = bus.en ? RUN : STOPPING;
                if (cnt_q == w_last) begin
                    cnt_d = '0;
                    if (mclk_q) begin
                        mclk_d = 1'b0;
                        fall_d = 1'b1;
                    end else if (bus.en) begin
                        mclk_d = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        mclk_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                mclk_d  = 1'b0;
            end
        endcase

        // A period start consumes the value that was already pending; a load
        // arriving on that same cycle overrides afterwards and stays pending.
        if (rise_d && pend_q) begin
            half_act_d = half_pend_q;
            pend_d     = 1'b0;
        end
        if (bus.div_load) begin
            half_pend_d = w_clamped;
            pend_d      = 1'b1;
        end

        w_active_d = (state_d != IDLE);
        running_d  = w_active_d;
        s0_d       = w_active_d &&  mclk_d && (cnt_d == c_SAMPLE_DELAY);
        s1_d       = w_active_d && !mclk_d && (cnt_d == c_SAMPLE_DELAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_act_q  <= c_DEFAULT_HALF;
            half_pend_q <= c_DEFAULT_HALF;
            pend_q      <= 1'b0;
            mclk_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_act_q  <= half_act_d;
            half_pend_q <= half_pend_d;
            pend_q      <= pend_d;
            mclk_q      <= mclk_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            running_q   <= running_d;
        end
    end

    assign bus.M_CLK         = mclk_q;
    assign bus.m_clk_rising  = rise_q;
    assign bus.m_clk_falling = fall_q;
    assign bus.sample_ch0    = s0_q;
    assign bus.sample_ch1    = s1_q;
    assign bus.running       = running_q;
    assign bus.div_pending   = pend_q;

endmodule : pdm_clk_ctrl
`default_nettype wire
